// File: rtl/morse_keyer.sv
// Morse keyer: plays one accepted symbol (dot/dash pattern + length) as a timed
// key waveform, with intra-letter spaces and a trailing letter/word gap.
module morse_keyer #(
    parameter int UNIT_TICKS = 10_000_000,
    parameter int MAX_ELEMS  = 5
) (
    input  logic                 clk_100Mhz,
    input  logic                 reset,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    input  logic [2:0]           sym_len,
    input  logic [MAX_ELEMS-1:0] sym_pattern,
    output logic                 key_out,
    output logic                 busy
);

    localparam int TW = $clog2(UNIT_TICKS);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

    // Captured symbol: elements still to send after the current one, and the
    // pattern shifted so bit 0 is always the current element.
    typedef struct packed {
        logic [2:0]           rem;
        logic [MAX_ELEMS-1:0] pat;
    } sym_t;

    state_t               state, state_nxt;
    sym_t                 sym_q, sym_nxt;
    logic [TW-1:0]        tick;
    logic [1:0]           units, units_load;   // holds units-1 of the phase
    logic                 enter, strobe, done;
    logic [2:0]           eff_len;
    logic [MAX_ELEMS-1:0] pat_shr;

    assign eff_len   = (sym_len > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : sym_len;
    assign pat_shr   = sym_q.pat >> 1;
    assign strobe    = (tick == TW'(UNIT_TICKS - 1));
    assign done      = strobe && (units == 2'd0);
    assign sym_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        sym_nxt    = sym_q;
        units_load = 2'd0;
        enter      = 1'b0;
        case (state)
            IDLE: begin
                if (sym_valid) begin
                    enter       = 1'b1;
                    sym_nxt.pat = sym_pattern;
                    if (eff_len == 3'd0) begin
                        state_nxt   = LGAP;
                        units_load  = 2'd3;
                        sym_nxt.rem = 3'd0;
                    end else begin
                        state_nxt   = MARK;
                        units_load  = sym_pattern[0] ? 2'd2 : 2'd0;
                        sym_nxt.rem = eff_len - 3'd1;
                    end
                end
            end
            MARK: begin
                if (done) begin
                    enter = 1'b1;
                    if (sym_q.rem != 3'd0) begin
                        state_nxt  = SPACE;
                        units_load = 2'd0;
                    end else begin
                        state_nxt  = LGAP;
                        units_load = 2'd2;
                    end
                end
            end
            SPACE: begin
                if (done) begin
                    enter       = 1'b1;
                    state_nxt   = MARK;
                    sym_nxt.rem = sym_q.rem - 3'd1;
                    sym_nxt.pat = pat_shr;
                    units_load  = pat_shr[0] ? 2'd2 : 2'd0;
                end
            end
            LGAP: begin
                if (done) begin
                    enter     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sym_q   <= '0;
            tick    <= '0;
            units   <= '0;
            key_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            sym_q   <= sym_nxt;
            // Registered from the next state so the mark starts right after accept.
            key_out <= (state_nxt == MARK);
            if (enter) begin
                tick  <= '0;
                units <= units_load;
            end else if (state != IDLE) begin
                if (strobe) begin
                    tick  <= '0;
                    units <= units - 2'd1;
                end else begin
                    tick  <= tick + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: directed test-plan symbols plus random symbols,
// compared cycle by cycle against a waveform built from the Morse timing rules.
module tb_morse_keyer;

    localparam int U  = 4;
    localparam int ME = 5;

    logic          clk_100Mhz = 1'b0;
    logic          reset      = 1'b1;
    logic          sym_valid  = 1'b0;
    logic [2:0]    sym_len    = '0;
    logic [ME-1:0] sym_pattern = '0;
    logic          sym_ready, key_out, busy;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    always #5 clk_100Mhz = ~clk_100Mhz;

    morse_keyer #(.UNIT_TICKS(U), .MAX_ELEMS(ME)) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_len    (sym_len),
        .sym_pattern(sym_pattern),
        .key_out    (key_out),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected key level for each cycle after the accept edge until ready returns.
    task automatic model(input int len, input logic [ME-1:0] pat);
        int n;
        n = (len > ME) ? ME : len;
        exp_q.delete();
        if (n == 0) begin
            repeat (4*U) exp_q.push_back(1'b0);
        end else begin
            for (int i = 0; i < n; i++) begin
                repeat ((pat[i] ? 3 : 1) * U) exp_q.push_back(1'b1);
                if (i < n-1) repeat (U) exp_q.push_back(1'b0);
            end
            repeat (3*U) exp_q.push_back(1'b0);
        end
    endtask

    // Called at posedge+1 with the keyer idle; returns at posedge+1 idle again.
    task automatic run_sym(input int len, input logic [ME-1:0] pat, input bit poke);
        model(len, pat);
        chk("ready_before", sym_ready, 1);
        sym_valid   = 1'b1;
        sym_len     = 3'(len);
        sym_pattern = pat;
        @(posedge clk_100Mhz); #1;
        sym_valid   = 1'b0;
        sym_len     = 3'($urandom);
        sym_pattern = ME'($urandom);
        foreach (exp_q[k]) begin
            chk($sformatf("key[%0d] len=%0d pat=%b", k, len, pat), key_out, exp_q[k]);
            chk($sformatf("busy[%0d]", k), busy, 1);
            chk($sformatf("ready_busy[%0d]", k), sym_ready, 0);
            if (poke) sym_valid = 1'($urandom);
            @(posedge clk_100Mhz); #1;
        end
        sym_valid = 1'b0;
        chk("ready_after", sym_ready, 1);
        chk("busy_after", busy, 0);
        chk("key_idle", key_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk_100Mhz);
        #1;
        chk("rst_key", key_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", sym_ready, 1);
        @(negedge clk_100Mhz) reset = 1'b0;
        @(posedge clk_100Mhz); #1;
        chk("post_rst_ready", sym_ready, 1);

        // "A" aborted by reset during its second (dash) mark
        model(2, 5'b00010);
        sym_valid = 1'b1; sym_len = 3'd2; sym_pattern = 5'b00010;
        @(posedge clk_100Mhz); #1;
        sym_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("abort_key[%0d]", k), key_out, exp_q[k]);
            @(posedge clk_100Mhz); #1;
        end
        chk("abort_key_dash", key_out, 1);
        reset = 1'b1;
        #1;
        chk("abort_key_async", key_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", sym_ready, 1);
        #2 reset = 1'b0;
        @(posedge clk_100Mhz); #1;
        chk("abort_key_rel", key_out, 0);
        run_sym(1, 5'b00000, 0);                 // "E" after reset

        run_sym(1, 5'b00000, 0);                 // "E"
        run_sym(2, 5'b00010, 0);                 // "A"
        run_sym(1, 5'b00000, 0);                 // "E" then word space back-to-back
        run_sym(0, 5'b10101, 0);
        run_sym(7, 5'b11111, 1);                 // clamp to five dashes, poke valid

        repeat (20) begin
            run_sym($urandom_range(0, 7), ME'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_100Mhz); #1;
                chk("idle_ready", sym_ready, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
